// File: rtl/op_exec_ctrl.sv
// Multi-cycle executor for the LC-3 ADD/AND/NOT operate instructions.
// It reads two register-file operands, computes, writes back once and updates the condition codes.
module op_exec_ctrl #(
  parameter logic [2:0] RESET_NZP = 3'b010
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [15:0] i_Instr,
  input  logic [15:0] i_SR1_OUT,
  input  logic [15:0] i_SR2_OUT,
  output logic [2:0]  o_SR1_SEL,
  output logic [2:0]  o_SR2_SEL,
  output logic [2:0]  o_DR,
  output logic        o_LD_REG,
  output logic [15:0] o_BUS,
  output logic [2:0]  o_NZP,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Illegal
);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StRead,
    StExec,
    StWb,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] a_q, b_q, res_q;
  logic [15:0] b_d, res_d;
  logic [2:0]  nzp_q, nzp_d;
  logic        illegal_q;
  logic        legal_op;

  assign legal_op = (ir_q[15:12] == 4'b0001) || (ir_q[15:12] == 4'b0101) ||
                    (ir_q[15:12] == 4'b1001);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (i_Start) state_d = StDecode;
      StDecode: state_d = legal_op ? StRead : StDone;
      StRead:   state_d = StExec;
      StExec:   state_d = StWb;
      StWb:     state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Immediate form sign-extends imm5; NOT ignores B entirely.
  assign b_d = ir_q[5] ? {{11{ir_q[4]}}, ir_q[4:0]} : i_SR2_OUT;

  always_comb begin
    case (ir_q[15:12])
      4'b0001: res_d = a_q + b_q;
      4'b0101: res_d = a_q & b_q;
      default: res_d = ~a_q;
    endcase
  end

  always_comb begin
    if (res_q[15])            nzp_d = 3'b100;
    else if (res_q == 16'h0)  nzp_d = 3'b010;
    else                      nzp_d = 3'b001;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      ir_q      <= 16'h0;
      a_q       <= 16'h0;
      b_q       <= 16'h0;
      res_q     <= 16'h0;
      nzp_q     <= RESET_NZP;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && i_Start) ir_q <= i_Instr;
      if (state_q == StDecode) illegal_q <= !legal_op;
      if (state_q == StRead) begin
        a_q <= i_SR1_OUT;
        b_q <= b_d;
      end
      if (state_q == StExec) res_q <= res_d;
      if (state_q == StWb) nzp_q <= nzp_d;
    end
  end

  always_comb begin
    o_SR1_SEL = 3'd0;
    o_SR2_SEL = 3'd0;
    o_DR      = 3'd0;
    if (state_q != StIdle) begin
      o_SR1_SEL = ir_q[8:6];
      o_SR2_SEL = ir_q[2:0];
      o_DR      = ir_q[11:9];
    end
  end

  // Bus is zero outside WB so it can be OR-merged with other drivers.
  assign o_BUS     = (state_q == StWb) ? res_q : 16'h0000;
  assign o_LD_REG  = (state_q == StWb) && !i_Rst;
  assign o_NZP     = nzp_q;
  assign o_Busy    = (state_q != StIdle);
  assign o_Done    = (state_q == StDone);
  assign o_Illegal = (state_q == StDone) && illegal_q;

endmodule

// File: tb/tb_op_exec_ctrl.sv
// Randomized bench for op_exec_ctrl: a transaction-level model predicts every output each cycle,
// plus directed cases with hand-computed values.
module tb_op_exec_ctrl;

  logic        clk = 1'b0;
  logic        i_Rst, i_Start;
  logic [15:0] i_Instr, i_SR1_OUT, i_SR2_OUT;
  logic [2:0]  o_SR1_SEL, o_SR2_SEL, o_DR, o_NZP;
  logic        o_LD_REG, o_Busy, o_Done, o_Illegal;
  logic [15:0] o_BUS;

  logic [15:0] rf [8];
  assign i_SR1_OUT = rf[o_SR1_SEL];
  assign i_SR2_OUT = rf[o_SR2_SEL];

  op_exec_ctrl #(.RESET_NZP(3'b010)) dut (
    .i_Clk(clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Instr(i_Instr),
    .i_SR1_OUT(i_SR1_OUT), .i_SR2_OUT(i_SR2_OUT),
    .o_SR1_SEL(o_SR1_SEL), .o_SR2_SEL(o_SR2_SEL), .o_DR(o_DR),
    .o_LD_REG(o_LD_REG), .o_BUS(o_BUS), .o_NZP(o_NZP),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Illegal(o_Illegal)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: one outstanding instruction, k = cycles since acceptance.
  bit          m_act = 0;
  bit          m_ill;
  int          m_k;
  logic [15:0] m_res;
  logic [15:0] m_ir;
  logic [2:0]  m_nzp = 3'b010;

  int          ld_cnt, ld_cyc, done_cnt, done_cyc;
  logic [15:0] last_bus;
  logic [2:0]  last_dr;
  logic        last_ill;
  int          done_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic cycle(input logic rst, input logic start, input logic [15:0] instr, input bit en);
    int          last;
    logic [15:0] a, b;
    logic [3:0]  op;
    @(negedge clk);
    i_Rst = rst; i_Start = start; i_Instr = instr;
    #1;
    last = m_ill ? 2 : 5;
    if (en) begin
      chk("busy", o_Busy, m_act);
      chk("done", o_Done, m_act && m_k == last);
      if (m_act && m_k == last) chk("illegal", o_Illegal, m_ill);
      chk("ld_reg", o_LD_REG, m_act && !m_ill && m_k == 4 && !rst);
      chk("bus", o_BUS, (m_act && !m_ill && m_k == 4) ? m_res : 16'h0);
      chk("nzp", o_NZP, m_nzp);
      if (!m_act) begin
        chk("sr1_idle", o_SR1_SEL, 3'd0);
        chk("sr2_idle", o_SR2_SEL, 3'd0);
        chk("dr_idle", o_DR, 3'd0);
      end else if (m_k <= (m_ill ? 1 : 4)) begin
        chk("sr1_sel", o_SR1_SEL, m_ir[8:6]);
        chk("sr2_sel", o_SR2_SEL, m_ir[2:0]);
        chk("dr", o_DR, m_ir[11:9]);
      end
    end
    if (o_LD_REG) begin ld_cnt++; ld_cyc = cyc; last_bus = o_BUS; last_dr = o_DR; end
    if (o_Done) begin done_cnt++; done_cyc = cyc; last_ill = o_Illegal; done_q.push_back(cyc); end
    if (rst) begin
      m_act = 0;
      m_nzp = 3'b010;
    end else if (m_act) begin
      if (!m_ill && m_k == 4) begin
        m_nzp = nzp_of(m_res);
        rf[m_ir[11:9]] = m_res;
      end
      if (m_k == last) m_act = 0;
      else m_k++;
    end else if (start) begin
      op    = instr[15:12];
      m_ir  = instr;
      m_ill = !(op == 4'b0001 || op == 4'b0101 || op == 4'b1001);
      a     = rf[instr[8:6]];
      b     = instr[5] ? {{11{instr[4]}}, instr[4:0]} : rf[instr[2:0]];
      m_res = (op == 4'b0001) ? a + b : (op == 4'b0101) ? (a & b) : ~a;
      m_act = 1;
      m_k   = 1;
    end
    cyc++;
  endtask

  // Issues one instruction, holds start high while busy when noisy, and checks latency literally.
  task automatic run_one(input logic [15:0] instr, input bit noisy, input bit ill);
    int c0;
    ld_cnt = 0; done_cnt = 0;
    c0 = cyc;
    cycle(0, 1, instr, 1);
    for (int i = 0; i < 5; i++) cycle(0, noisy, 16'h1000 | 16'($urandom_range(0, 4095)), 1);
    cycle(0, 0, 16'h0, 1);
    chk("done_count", 16'(done_cnt), 16'd1);
    chk("done_latency", 16'(done_cyc - c0), ill ? 16'd2 : 16'd5);
    chk("illegal_flag", {15'd0, last_ill}, {15'd0, ill});
    chk("ld_count", 16'(ld_cnt), ill ? 16'd0 : 16'd1);
    if (!ill) chk("ld_latency", 16'(ld_cyc - c0), 16'd4);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0: w[15:12] = 4'b0001;
      1: w[15:12] = 4'b0101;
      2: w[15:12] = 4'b1001;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    int c0;
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    i_Rst = 1; i_Start = 0; i_Instr = 0;
    cycle(1, 0, 16'h0, 0);
    cycle(1, 1, 16'h1283, 1);
    chk("reset_nzp", o_NZP, 3'b010);
    chk("reset_busy", o_Busy, 1'b0);

    rf[2] = 16'h0005; rf[3] = 16'h0003;
    run_one(16'h1283, 1, 0);
    chk("add_bus", last_bus, 16'h0008);
    chk("add_dr", last_dr, 3'd1);
    chk("add_nzp", o_NZP, 3'b001);
    chk("add_rf", rf[1], 16'h0008);

    rf[2] = 16'h0001;
    run_one(16'h18BE, 0, 0);
    chk("addi_bus", last_bus, 16'hFFFF);
    chk("addi_dr", last_dr, 3'd4);
    chk("addi_nzp", o_NZP, 3'b100);

    rf[5] = 16'h1234;
    run_one(16'h5B60, 0, 0);
    chk("and_bus", last_bus, 16'h0000);
    chk("and_dr", last_dr, 3'd5);
    chk("and_nzp", o_NZP, 3'b010);

    rf[7] = 16'h8000;
    run_one(16'h91FF, 0, 0);
    chk("not_bus", last_bus, 16'h7FFF);
    chk("not_dr", last_dr, 3'd0);
    chk("not_nzp", o_NZP, 3'b001);

    run_one(16'h0000, 0, 1);
    chk("ill_nzp", o_NZP, 3'b001);

    // Reset during EXEC (k=3) and then WB (k=4).
    for (int r = 3; r <= 4; r++) begin
      rf[2] = 16'h0005; rf[3] = 16'h0003;
      ld_cnt = 0;
      cycle(0, 1, 16'h1283, 1);
      for (int i = 1; i < r; i++) cycle(0, 0, 16'h0, 1);
      cycle(1, 1, 16'h1283, 1);
      cycle(0, 0, 16'h0, 1);
      chk("rst_busy", o_Busy, 1'b0);
      chk("rst_nzp", o_NZP, 3'b010);
      chk("rst_ld", 16'(ld_cnt), 16'd0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 1);
    end

    // Start held high: acceptances every 6 cycles.
    done_q.delete();
    c0 = cyc;
    for (int i = 0; i < 36; i++) cycle(0, 1, {4'b0001, 12'($urandom)}, 1);
    chk("b2b_count", 16'(done_q.size()), 16'd6);
    for (int i = 0; i < done_q.size(); i++)
      chk("b2b_spacing", 16'(done_q[i] - c0), 16'(6 * i + 5));
    for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++)
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), rand_instr(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/op_exec_ctrl.md
OP_EXEC_CTRL -- requirements
Module: op_exec_ctrl

Interface
REQ-001 Parameter RESET_NZP, default 3'b010, SHALL be the condition-code value loaded on reset.
REQ-002 i_Clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 i_Rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 i_Start  in  1  SHALL request execution of i_Instr; sampled only in IDLE.
REQ-005 i_Instr  in  16  SHALL be the LC-3 instruction word, captured into IR when a start is accepted.
REQ-006 i_SR1_OUT, i_SR2_OUT  in  16 each  SHALL be register-file read data for o_SR1_SEL and o_SR2_SEL, combinational, same cycle.
REQ-007 o_SR1_SEL, o_SR2_SEL, o_DR  out  3 each  SHALL be the register-file read selects and write select.
REQ-008 o_LD_REG  out  1  SHALL be the register-file write enable.
REQ-009 o_BUS  out  16  SHALL be the write-back data.
REQ-010 o_NZP  out  3  SHALL be the condition codes {N,Z,P}.
REQ-011 o_Busy, o_Done, o_Illegal  out  1 each  SHALL be the status outputs.

Function
REQ-012 The FSM SHALL have the states IDLE, DECODE, READ, EXEC, WB and DONE.
REQ-013 In IDLE with i_Start=1, the block SHALL latch i_Instr into IR and enter DECODE; i_Start SHALL be ignored in every other state.
REQ-014 In DECODE, opcode IR[15:12] SHALL be classified as 0001 ADD, 0101 AND or 1001 NOT.
REQ-015 Any other opcode SHALL go to DONE with o_Illegal=1, with no register write and no NZP change.
REQ-016 From DECODE through WB, o_SR1_SEL=IR[8:6], o_SR2_SEL=IR[2:0] and o_DR=IR[11:9] SHALL hold constant; in IDLE all three SHALL be 0.
REQ-017 In READ, the block SHALL register A=i_SR1_OUT.
REQ-018 In READ, the block SHALL register B as sign-extended IR[4:0] when IR[5]=1, else i_SR2_OUT; NOT ignores B.
REQ-019 In EXEC, the block SHALL register the result: ADD A+B modulo 2^16 with carry discarded; AND A&B; NOT ~A.
REQ-020 In WB, o_BUS SHALL equal the result and o_LD_REG SHALL be (state==WB) AND NOT i_Rst, high for exactly one cycle.
REQ-021 Outside WB, o_BUS SHALL be 16'h0000 so that it may be OR-combined onto the shared bus.
REQ-022 At the WB-ending edge, o_NZP SHALL load 100 when result[15]=1, 010 when result==0, else 001; o_NZP SHALL always be one-hot.
REQ-023 In DONE, o_Done SHALL be 1 for one cycle, then the FSM SHALL enter IDLE; o_Illegal SHALL be valid only while o_Done=1.
REQ-024 Latency: with the start accepted at edge T, o_LD_REG SHALL be high in cycle T+4 and o_Done in cycle T+5; for an illegal opcode, o_Done SHALL be high in cycle T+2.
REQ-025 o_Busy SHALL be 1 in every state except IDLE, including DONE.
REQ-026 When o_DR equals a source select, operands SHALL already be latched in READ, so the result uses pre-write values.
REQ-027 A start arriving in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted, giving back-to-back issue every 6 cycles.

Reset
REQ-028 i_Rst=1 SHALL force, at the next edge, state=IDLE, IR=0, A=B=result=0 and o_NZP=RESET_NZP.
REQ-029 i_Rst=1 SHALL force o_Done=o_Illegal=o_Busy=0 in the following cycle, regardless of the current state.
REQ-030 During a cycle in which i_Rst=1, o_LD_REG SHALL be 0 even in WB, so no write occurs on reset mid-operation.
REQ-031 Reset SHALL take priority over i_Start in the same cycle.

Verification
REQ-032 R2=0x0005, R3=0x0003, start with 0x1283 (ADD R1,R2,R3) -> o_LD_REG=1, o_DR=1, o_BUS=0x0008 at T+4; o_NZP=001; o_Done at T+5.
REQ-033 R2=0x0001, instruction 0x18BE (ADD R4,R2,#-2) -> o_BUS=0xFFFF, o_DR=4, o_NZP=100.
REQ-034 R5=0x1234, instruction 0x5B60 (AND R5,R5,#0) -> o_BUS=0x0000, o_DR=5, o_NZP=010; instruction 0x91FF (NOT R0,R7) with R7=0x8000 -> o_BUS=0x7FFF, o_NZP=001.
REQ-035 Instruction 0x0000 (BR, illegal here) -> o_Done=o_Illegal=1 at T+2, o_LD_REG never high, o_NZP unchanged.
REQ-036 Assert i_Rst in the EXEC or WB cycle of an ADD -> o_LD_REG=0 throughout, IDLE next cycle, o_NZP=010, o_Busy=0.
REQ-037 Hold i_Start=1 continuously -> acceptances exactly 6 cycles apart, each producing exactly one o_Done pulse.
